// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the fetch unit: FSM encoding, next-PC select codes,
// RV32I major opcodes and the conditional-branch decision.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } fetch_state_e;

  // PCS encoding 2'b11 also selects sequential flow.
  localparam logic [1:0] PCS_BRANCH = 2'b00;
  localparam logic [1:0] PCS_JUMP   = 2'b01;
  localparam logic [1:0] PCS_SEQ    = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // BNE takes on a nonzero difference, BGE on a non-negative one.
  function automatic logic branch_taken(input logic bs, input logic zero, input logic neg);
    return (bs & ~zero) | (~bs & ~neg);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and memory (slave).
interface pc_fetch_unit_if;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_ADDR,
    output IMEM_REQ,
    input  IMEM_ACK,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_ADDR,
    input  IMEM_REQ,
    output IMEM_ACK,
    output IMEM_RDATA
  );
endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, jump target or conditional branch.
module next_pc_calc
  import riscv_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcs_i,
  input  logic        bs_i,
  input  logic        zero_i,
  input  logic        neg_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + 32'd4;

  // Jump targets drop bit 0 the way JALR does; bit 1 is left for the misalign check.
  always_comb begin
    next_pc_o = pc_plus4_o;
    case (pcs_i)
      PCS_BRANCH: next_pc_o = branch_taken(bs_i, zero_i, neg_i) ? (pc_i + imm_i) : pc_plus4_o;
      PCS_JUMP:   next_pc_o = alu_result_i & 32'hFFFF_FFFE;
      default:    next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer: fetches one word, holds it
// for execute, then commits the next PC or halts on a misaligned target.
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  pc_fetch_unit_if.master    imem,
  input  logic [1:0]         PCS,
  input  logic               BS,
  input  logic               ZERO,
  input  logic               NEG,
  input  logic [31:0]        IMM,
  input  logic [31:0]        ALU_RESULT,
  input  logic               EXEC_DONE,
  output logic [31:0]        INSTR,
  output logic [6:0]         OP_CODE,
  output logic [2:0]         FUNCT_3,
  output logic [6:0]         FUNCT_7,
  output logic               INSTR_VALID,
  output logic [31:0]        PC,
  output logic [31:0]        PC_PLUS4,
  output logic               MISALIGN
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         req_q;
  logic         misalign_q;

  next_pc_calc u_next_pc_calc (
    .pc_i         (pc_q),
    .pcs_i        (PCS),
    .bs_i         (BS),
    .zero_i       (ZERO),
    .neg_i        (NEG),
    .imm_i        (IMM),
    .alu_result_i (ALU_RESULT),
    .next_pc_o    (pc_d),
    .pc_plus4_o   (PC_PLUS4)
  );

  // ACK and EXEC_DONE only act in their own state, so stray pulses are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem.IMEM_ACK) begin
            instr_q <= imem.IMEM_RDATA;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (EXEC_DONE) begin
            valid_q <= 1'b0;
            if (pc_d[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state_q    <= HALT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.IMEM_ADDR = pc_q;
  assign imem.IMEM_REQ  = req_q;
  assign PC             = pc_q;
  assign INSTR          = instr_q;
  assign OP_CODE        = instr_q[6:0];
  assign FUNCT_3        = instr_q[14:12];
  assign FUNCT_7        = instr_q[31:25];
  assign INSTR_VALID    = valid_q;
  assign MISALIGN       = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed PC values.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  PCS;
  logic        BS, ZERO, NEG;
  logic [31:0] IMM, ALU_RESULT;
  logic        EXEC_DONE;
  logic [31:0] INSTR, PC, PC_PLUS4;
  logic [6:0]  OP_CODE, FUNCT_7;
  logic [2:0]  FUNCT_3;
  logic        INSTR_VALID, MISALIGN;
  int          total = 0;
  int          bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imem       (bus),
    .PCS        (PCS),
    .BS         (BS),
    .ZERO       (ZERO),
    .NEG        (NEG),
    .IMM        (IMM),
    .ALU_RESULT (ALU_RESULT),
    .EXEC_DONE  (EXEC_DONE),
    .INSTR      (INSTR),
    .OP_CODE    (OP_CODE),
    .FUNCT_3    (FUNCT_3),
    .FUNCT_7    (FUNCT_7),
    .INSTR_VALID(INSTR_VALID),
    .PC         (PC),
    .PC_PLUS4   (PC_PLUS4),
    .MISALIGN   (MISALIGN)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Drives one commit from EXEC; returns at the negedge after the commit edge.
  task automatic applyStimulus(input logic [1:0] pcs, input logic bs, input logic zero,
                               input logic neg, input logic [31:0] imm, input logic [31:0] alu);
    PCS        = pcs;
    BS         = bs;
    ZERO       = zero;
    NEG        = neg;
    IMM        = imm;
    ALU_RESULT = alu;
    EXEC_DONE  = 1'b1;
    @(negedge CLK);
    EXEC_DONE  = 1'b0;
  endtask

  task automatic waitReq();
    int n = 0;
    while (bus.IMEM_REQ !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n == 20) checkOutput("reqTimeout", 32'd0, 32'd1);
  endtask

  task automatic fetchInstr(input logic [31:0] word, input int waits, input logic [31:0] expAddr);
    waitReq();
    checkOutput("fetchAddr", bus.IMEM_ADDR, expAddr);
    repeat (waits) @(negedge CLK);
    bus.IMEM_ACK   = 1'b1;
    bus.IMEM_RDATA = word;
    @(negedge CLK);
    bus.IMEM_ACK   = 1'b0;
    checkOutput("fetchValid", {31'd0, INSTR_VALID}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1; PCS = 2'b10; BS = 1'b0; ZERO = 1'b0; NEG = 1'b0;
    IMM = '0; ALU_RESULT = '0; EXEC_DONE = 1'b0;
    bus.IMEM_ACK = 1'b0; bus.IMEM_RDATA = '0;
    repeat (2) @(negedge CLK);

    checkOutput("rstPc",       PC, 32'h0);
    checkOutput("rstReq",      {31'd0, bus.IMEM_REQ}, 32'd0);
    checkOutput("rstValid",    {31'd0, INSTR_VALID}, 32'd0);
    checkOutput("rstInstr",    INSTR, 32'h0);
    checkOutput("rstMisalign", {31'd0, MISALIGN}, 32'd0);

    // One IDLE cycle, then a fetch that waits two cycles for ACK
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("wait1Req",   {31'd0, bus.IMEM_REQ}, 32'd1);
    checkOutput("wait1Addr",  bus.IMEM_ADDR, 32'h0);
    checkOutput("wait1Valid", {31'd0, INSTR_VALID}, 32'd0);
    @(negedge CLK);
    checkOutput("wait2Req",   {31'd0, bus.IMEM_REQ}, 32'd1);
    bus.IMEM_ACK = 1'b1; bus.IMEM_RDATA = 32'h0050_0093;
    @(negedge CLK);
    bus.IMEM_ACK = 1'b0;
    checkOutput("firstValid",  {31'd0, INSTR_VALID}, 32'd1);
    checkOutput("firstOpcode", {25'd0, OP_CODE}, 32'h13);
    checkOutput("firstFunct3", {29'd0, FUNCT_3}, 32'h0);
    checkOutput("firstFunct7", {25'd0, FUNCT_7}, 32'h0);
    checkOutput("firstReqLow", {31'd0, bus.IMEM_REQ}, 32'd0);

    // ACK in EXEC must not disturb the latched word
    bus.IMEM_ACK = 1'b1; bus.IMEM_RDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    bus.IMEM_ACK = 1'b0;
    @(negedge CLK);
    checkOutput("execInstr", INSTR, 32'h0050_0093);
    checkOutput("execValid", {31'd0, INSTR_VALID}, 32'd1);
    checkOutput("execPc",    PC, 32'h0);

    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("seqPc4", PC, 32'h4);
    fetchInstr(NOP, 0, 32'h4);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("seq11Pc8", PC, 32'h8);
    fetchInstr(NOP, 1, 32'h8);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetchInstr(NOP, 0, 32'hC);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetchInstr(NOP, 0, 32'h10);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("seqAddr14",  bus.IMEM_ADDR, 32'h14);
    checkOutput("seqReq14",   {31'd0, bus.IMEM_REQ}, 32'd1);
    checkOutput("seqPlus4",   PC_PLUS4, 32'h18);
    checkOutput("seqValid0",  {31'd0, INSTR_VALID}, 32'd0);

    fetchInstr(NOP, 0, 32'h14);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetchInstr(NOP, 0, 32'h18);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetchInstr(NOP, 0, 32'h1C);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetchInstr(32'h0000_0063, 0, 32'h20);

    // Branches: BNE taken backwards, BGE not taken, BNE not taken
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
    checkOutput("bneTaken", PC, 32'h18);
    fetchInstr(NOP, 0, 32'h18);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    checkOutput("bgeNotTaken", PC, 32'h1C);
    fetchInstr(NOP, 0, 32'h1C);
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    checkOutput("bneNotTaken", PC, 32'h20);
    fetchInstr(NOP, 0, 32'h20);
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    checkOutput("bgeTaken", PC, 32'h60);

    // Jumps clear bit 0; then wrap past the top of the address space
    fetchInstr(NOP, 0, 32'h60);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0101);
    checkOutput("jumpPc", PC, 32'h100);
    fetchInstr(NOP, 0, 32'h100);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    checkOutput("jumpTop",   PC, 32'hFFFF_FFFC);
    checkOutput("topPlus4",  PC_PLUS4, 32'h0);
    fetchInstr(NOP, 0, 32'hFFFF_FFFC);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wrapPc", PC, 32'h0);

    // EXEC_DONE while fetching is ignored
    PCS = 2'b01; ALU_RESULT = 32'h200; EXEC_DONE = 1'b1;
    @(negedge CLK);
    EXEC_DONE = 1'b0;
    checkOutput("doneInFetchPc",  PC, 32'h0);
    checkOutput("doneInFetchReq", {31'd0, bus.IMEM_REQ}, 32'd1);

    // Misaligned branch target halts without moving PC
    fetchInstr(NOP, 0, 32'h0);
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h0);
    checkOutput("misalignSet",   {31'd0, MISALIGN}, 32'd1);
    checkOutput("misalignPc",    PC, 32'h0);
    checkOutput("misalignReq",   {31'd0, bus.IMEM_REQ}, 32'd0);
    checkOutput("misalignValid", {31'd0, INSTR_VALID}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.IMEM_ACK = 1'b1; EXEC_DONE = 1'b1; PCS = 2'b10;
      @(negedge CLK);
      checkOutput("haltReq",   {31'd0, bus.IMEM_REQ}, 32'd0);
      checkOutput("haltValid", {31'd0, INSTR_VALID}, 32'd0);
    end
    bus.IMEM_ACK = 1'b0; EXEC_DONE = 1'b0;
    checkOutput("haltSticky", {31'd0, MISALIGN}, 32'd1);

    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("clearMisalign", {31'd0, MISALIGN}, 32'd0);

    // Reset mid-fetch with ACK in the same and the following cycle
    fetchInstr(NOP, 1, 32'h0);
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("preRstAddr", bus.IMEM_ADDR, 32'h4);
    RST = 1'b1; bus.IMEM_ACK = 1'b1; bus.IMEM_RDATA = 32'h1234_5678;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    bus.IMEM_ACK = 1'b0;
    checkOutput("lateAckAddr",  bus.IMEM_ADDR, 32'h0);
    checkOutput("lateAckValid", {31'd0, INSTR_VALID}, 32'd0);
    checkOutput("lateAckInstr", INSTR, 32'h0);
    checkOutput("lateAckReq",   {31'd0, bus.IMEM_REQ}, 32'd1);
    @(negedge CLK);
    checkOutput("lateAckStill", {31'd0, INSTR_VALID}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
